// File: rtl/ant_pheromone_table.sv
// Pheromone store for ant-colony routing: one value per (destination, network port),
// reinforced by backward ants and queried for the strongest output port.
module ant_pheromone_table #(
    parameter int X_LOC      = 0,
    parameter int Y_LOC      = 0,
    parameter int X_NODES    = 4,
    parameter int Y_NODES    = 4,
    parameter int N          = 5,
    parameter int P_WIDTH    = 8,
    parameter int P_INIT     = 64,
    parameter int REWARD     = 32,
    parameter int EVAP_SHIFT = 3,
    parameter int P_FLOOR    = 1,
    localparam int XW        = $clog2(X_NODES),
    localparam int YW        = $clog2(Y_NODES),
    localparam int PW        = $clog2(N)
) (
    input  logic          i_clk,
    input  logic          i_reset,
    input  logic          i_upd_val,
    output logic          o_upd_rdy,
    input  logic [XW-1:0] i_upd_x_dest,
    input  logic [YW-1:0] i_upd_y_dest,
    input  logic [PW-1:0] i_upd_port,
    input  logic          i_lkp_val,
    input  logic [XW-1:0] i_lkp_x_dest,
    input  logic [YW-1:0] i_lkp_y_dest,
    output logic          o_lkp_val,
    output logic [PW-1:0] o_lkp_port,
    output logic          o_init_busy
);

    localparam int ENTRIES = X_NODES * Y_NODES;
    localparam int CW      = $clog2(ENTRIES);

    typedef enum logic [1:0] {INIT, IDLE, READ, WRITE} state_t;

    state_t                      state_reg;
    logic [CW-1:0]               cnt_reg;
    logic [CW-1:0]               upd_idx_reg;
    logic [PW-1:0]               upd_port_reg;
    logic                        upd_drop_reg;
    logic [N-2:0][P_WIDTH-1:0]   new_reg;
    logic [N-2:0][P_WIDTH-1:0]   new_next;
    logic [N-2:0][P_WIDTH-1:0]   table_reg [ENTRIES];

    logic [CW-1:0]               upd_idx;
    logic                        upd_drop;
    logic [CW-1:0]               lkp_idx;
    logic                        lkp_local;
    logic [N-2:0][P_WIDTH-1:0]   lkp_entry;
    logic [P_WIDTH-1:0]          best_val;
    logic [PW-1:0]               best_port;

    assign upd_idx  = CW'(int'(i_upd_y_dest) * X_NODES + int'(i_upd_x_dest));
    assign upd_drop = (int'(i_upd_x_dest) == X_LOC && int'(i_upd_y_dest) == Y_LOC)
                      || (i_upd_port == '0) || (int'(i_upd_port) >= N);

    // Per-port new value: saturating reward on the reinforced port, floored evaporation elsewhere.
    generate
        for (genvar gi = 0; gi < N - 1; gi++) begin : g_port
            logic [P_WIDTH-1:0] cur_val;
            logic [P_WIDTH-1:0] evap_val;
            logic [P_WIDTH:0]   sum_val;
            assign cur_val  = table_reg[upd_idx_reg][gi];
            assign sum_val  = {1'b0, cur_val} + (P_WIDTH+1)'(REWARD);
            assign evap_val = cur_val - (cur_val >> EVAP_SHIFT);
            assign new_next[gi] = (int'(upd_port_reg) == gi + 1)
                                  ? (sum_val[P_WIDTH] ? '1 : sum_val[P_WIDTH-1:0])
                                  : ((evap_val < P_WIDTH'(P_FLOOR)) ? P_WIDTH'(P_FLOOR) : evap_val);
        end
    endgenerate

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_reg    <= INIT;
            cnt_reg      <= '0;
            o_upd_rdy    <= 1'b0;
            o_init_busy  <= 1'b1;
            upd_idx_reg  <= '0;
            upd_port_reg <= '0;
            upd_drop_reg <= 1'b0;
            new_reg      <= '0;
        end else begin
            case (state_reg)
                INIT: begin
                    cnt_reg <= cnt_reg + 1'b1;
                    if (cnt_reg == CW'(ENTRIES - 1)) begin
                        state_reg   <= IDLE;
                        o_init_busy <= 1'b0;
                        o_upd_rdy   <= 1'b1;
                    end
                end
                IDLE: begin
                    if (i_upd_val) begin
                        upd_idx_reg  <= upd_idx;
                        upd_port_reg <= i_upd_port;
                        upd_drop_reg <= upd_drop;
                        o_upd_rdy    <= 1'b0;
                        state_reg    <= READ;
                    end
                end
                READ: begin
                    new_reg   <= new_next;
                    state_reg <= WRITE;
                end
                WRITE: begin
                    o_upd_rdy <= 1'b1;
                    state_reg <= IDLE;
                end
                default: state_reg <= INIT;
            endcase
        end
    end

    // Table writes are gated by reset so an update interrupted by reset never commits.
    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            if (state_reg == INIT)
                table_reg[cnt_reg] <= {(N-1){P_WIDTH'(P_INIT)}};
            else if (state_reg == WRITE && !upd_drop_reg)
                table_reg[upd_idx_reg] <= new_reg;
        end
    end

    assign lkp_idx   = CW'(int'(i_lkp_y_dest) * X_NODES + int'(i_lkp_x_dest));
    assign lkp_local = (int'(i_lkp_x_dest) == X_LOC) && (int'(i_lkp_y_dest) == Y_LOC);
    assign lkp_entry = table_reg[lkp_idx];

    // Strict greater-than while scanning upward keeps ties on the lowest port.
    always_comb begin
        best_val  = lkp_entry[0];
        best_port = PW'(1);
        for (int i = 1; i < N - 1; i++) begin
            if (lkp_entry[i] > best_val) begin
                best_val  = lkp_entry[i];
                best_port = PW'(i + 1);
            end
        end
        if (lkp_local)
            best_port = '0;
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            o_lkp_val  <= 1'b0;
            o_lkp_port <= '0;
        end else begin
            o_lkp_val <= i_lkp_val && (state_reg != INIT);
            if (i_lkp_val && state_reg != INIT)
                o_lkp_port <= best_port;
        end
    end

endmodule

// File: doc/ant_pheromone_table.md
# ant_pheromone_table

Per-router pheromone store for the ant-colony routing path. It consumes backward-ant reinforcement events produced by the router's ant agent stage. It keeps one pheromone value per (destination node, output port) and answers forward-ant / data route lookups with the strongest output port. It sits beside the ant agent inside each router, one instance per (X_LOC, Y_LOC).

## Interface
- X_LOC, none, this router's X coordinate
- Y_LOC, none, this router's Y coordinate
- X_NODES, 4, mesh width
- Y_NODES, 4, mesh height
- N, 5, output ports; port 0 is local, ports 1..N-1 are network ports
- P_WIDTH, 8, pheromone value width (unsigned)
- P_INIT, 64, value loaded into every network-port entry at initialisation
- REWARD, 32, amount added to the reinforced port per update
- EVAP_SHIFT, 3, evaporation amount per update is value >> EVAP_SHIFT
- P_FLOOR, 1, minimum value after evaporation
- i_clk  in  1  clock
- i_reset  in  1  synchronous, active-high reset
- i_upd_val  in  1  reinforcement request valid
- o_upd_rdy  out  1  table accepts a reinforcement request this cycle
- i_upd_x_dest, i_upd_y_dest  in  $clog2(X_NODES), $clog2(Y_NODES)  destination the backward ant reports on
- i_upd_port  in  $clog2(N)  output port to reinforce
- i_lkp_val  in  1  lookup request valid
- i_lkp_x_dest, i_lkp_y_dest  in  $clog2(X_NODES), $clog2(Y_NODES)  lookup destination
- o_lkp_val  out  1  lookup result valid
- o_lkp_port  out  $clog2(N)  selected output port
- o_init_busy  out  1  initialisation sweep in progress

## Operation
- Storage: X_NODES*Y_NODES entries, indexed y*X_NODES+x. Each entry holds N-1 values of P_WIDTH bits, one per network port. Held in flops.
- FSM states:
  - INIT: write P_INIT to entry[cnt] each cycle, cnt 0..X_NODES*Y_NODES-1; after the last entry go to IDLE.
  - IDLE: o_upd_rdy=1. On i_upd_val go to READ, capturing dest and port.
  - READ: latch the selected entry and compute new values.
  - WRITE: commit the entry, then return to IDLE.
- Reset (any state, including mid-update): state=INIT, cnt=0, any partial update discarded.
- Update arithmetic:
  - Reinforced port p: min(v+REWARD, 2^P_WIDTH-1), computed at P_WIDTH+1 bits.
  - Every other network port q: max(v - (v>>EVAP_SHIFT), P_FLOOR).
- Dropped updates are accepted (handshake completes) but the table is unchanged. An update is dropped when:
  - dest == (X_LOC, Y_LOC),
  - i_upd_port == 0, or
  - i_upd_port >= N.
- Lookup:
  - dest == (X_LOC, Y_LOC): result is port 0.
  - Otherwise: the network port with the maximum value; ties go to the lowest index.
  - Lookups are served in IDLE, READ and WRITE, and always read the committed table.
  - Lookups issued while o_init_busy=1 are ignored.

## Timing
- Reset values: o_upd_rdy=0, o_lkp_val=0, o_lkp_port=0, o_init_busy=1.
- INIT lasts X_NODES*Y_NODES cycles after reset deasserts; o_upd_rdy rises in the next cycle.
- Update handshake: transfer when i_upd_val && o_upd_rdy.
  - o_upd_rdy=0 in READ and WRITE, so one update per 3 cycles maximum.
  - The new values are visible to a lookup issued the cycle after WRITE.
- Lookup latency: 1 cycle, fully pipelined.
  - o_lkp_val(t+1)=i_lkp_val(t), gated by INIT.
  - o_lkp_port is held when o_lkp_val=0.
- A lookup issued in the WRITE cycle to the same dest returns the pre-update result.
- Update and lookup in the same cycle are both accepted; there is no priority conflict.

## Test plan
Use defaults, X_LOC=0, Y_LOC=0.
- Reset 1 cycle, then idle: o_init_busy=1 for 16 cycles; o_upd_rdy=1 from cycle 16; lookup during INIT gives no o_lkp_val.
- After INIT, lookup (2,1) -> o_lkp_port=1 (all 64, lowest index wins); lookup (0,0) -> port 0.
- Update (2,1) port 3, then lookup (2,1):
  - port 3 = 96, ports 1, 2, 4 = 56;
  - o_upd_rdy low for exactly 2 cycles;
  - result port 3.
- Six updates (2,1) port 3:
  - port 3 goes 96, 128, 160, 192, 224, 255 (saturates);
  - others go 56, 49, 43, 38, 34, 30.
- Dropped updates: dest (0,0), port 0 and port 7 are each accepted, and all entries stay unchanged.
- Reset asserted in the READ cycle: no commit, INIT restarts, and afterwards all entries = 64.
